// File: rtl/audio_mixer_pwm.sv
// rtl/audio_mixer_pwm.sv - four-channel mixer, master volume and glitch-free PWM DAC output
// Optional AUDIO_MIXER_SOFT_MUTE_EN: mute/unmute ramp duty in steps of 8 per update.
module audio_mixer_pwm #(
  parameter int SAMPLE_PERIODS = 1
) (
  input  logic       clk50mhz,
  input  logic       rst_n,
  input  logic [3:0] ch0_in,
  input  logic [3:0] ch1_in,
  input  logic [3:0] ch2_in,
  input  logic [3:0] ch3_in,
  input  logic [3:0] ch_en,
  input  logic [2:0] master_vol,
  input  logic       mute,
  output logic       pwm_out,
  output logic [7:0] level_out,
  output logic       sample_strobe
);

  localparam logic [3:0] PER_LAST = 4'(SAMPLE_PERIODS - 1);

  logic [7:0] pwm_cnt_q, pwm_cnt_d;
  logic [3:0] per_cnt_q, per_cnt_d;
  logic [5:0] sum_r_q, sum_r_d;
  logic [2:0] vol_r_q, vol_r_d;
  logic [7:0] scaled_r_q, scaled_r_d;
  logic [7:0] duty_q, duty_d;
  logic       pwm_out_q, pwm_out_d;
  logic       sample_strobe_q, sample_strobe_d;
  logic       boundary, update;
  logic [8:0] product;
`ifdef AUDIO_MIXER_SOFT_MUTE_EN
  logic       ramp_q, ramp_d;
`endif

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 8'd1;
    boundary  = (pwm_cnt_q == 8'hFF);
    update    = boundary && (per_cnt_q == PER_LAST);

    per_cnt_d = per_cnt_q;
    if (boundary) begin
      per_cnt_d = (per_cnt_q == PER_LAST) ? 4'd0 : per_cnt_q + 4'd1;
    end

    sum_r_d = {2'b00, ch0_in & {4{ch_en[0]}}}
            + {2'b00, ch1_in & {4{ch_en[1]}}}
            + {2'b00, ch2_in & {4{ch_en[2]}}}
            + {2'b00, ch3_in & {4{ch_en[3]}}};
    vol_r_d = master_vol;

    product    = {3'b000, sum_r_q} * {5'b00000, ({1'b0, vol_r_q} + 4'd1)};
    scaled_r_d = product[8:1];

    // Comparing against the registered duty keeps the high time exactly duty clocks.
    pwm_out_d       = (pwm_cnt_q < duty_q);
    sample_strobe_d = update;
  end

`ifdef AUDIO_MIXER_SOFT_MUTE_EN
  // Ramp only across mute transitions; ordinary level changes still jump.
  always_comb begin
    duty_d = duty_q;
    ramp_d = ramp_q;
    if (update) begin
      if (mute) begin
        ramp_d = 1'b1;
        duty_d = (duty_q > 8'd8) ? duty_q - 8'd8 : 8'd0;
      end else if (ramp_q) begin
        if (duty_q < scaled_r_q) begin
          duty_d = ((scaled_r_q - duty_q) > 8'd8) ? duty_q + 8'd8 : scaled_r_q;
        end else if (duty_q > scaled_r_q) begin
          duty_d = ((duty_q - scaled_r_q) > 8'd8) ? duty_q - 8'd8 : scaled_r_q;
        end
        ramp_d = (duty_d != scaled_r_q);
      end else begin
        duty_d = scaled_r_q;
      end
    end
  end
`else
  always_comb begin
    duty_d = duty_q;
    if (update) begin
      duty_d = mute ? 8'd0 : scaled_r_q;
    end
  end
`endif

  always_ff @(posedge clk50mhz or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q       <= 8'd0;
      per_cnt_q       <= 4'd0;
      sum_r_q         <= 6'd0;
      vol_r_q         <= 3'd0;
      scaled_r_q      <= 8'd0;
      duty_q          <= 8'd0;
      pwm_out_q       <= 1'b0;
      sample_strobe_q <= 1'b0;
`ifdef AUDIO_MIXER_SOFT_MUTE_EN
      ramp_q          <= 1'b0;
`endif
    end else begin
      pwm_cnt_q       <= pwm_cnt_d;
      per_cnt_q       <= per_cnt_d;
      sum_r_q         <= sum_r_d;
      vol_r_q         <= vol_r_d;
      scaled_r_q      <= scaled_r_d;
      duty_q          <= duty_d;
      pwm_out_q       <= pwm_out_d;
      sample_strobe_q <= sample_strobe_d;
`ifdef AUDIO_MIXER_SOFT_MUTE_EN
      ramp_q          <= ramp_d;
`endif
    end
  end

  assign pwm_out       = pwm_out_q;
  assign level_out     = duty_q;
  assign sample_strobe = sample_strobe_q;

endmodule

// File: tb/tb_audio_mixer_pwm.sv
// tb/tb_audio_mixer_pwm.sv - directed and randomized checks of audio_mixer_pwm
// Two instances: SAMPLE_PERIODS=1 (main) and SAMPLE_PERIODS=4 (strobe spacing and reset).
module tb_audio_mixer_pwm;

  logic       clk50mhz = 1'b0;
  logic       rst_n, rst4_n;
  logic [3:0] ch0, ch1, ch2, ch3, ch_en;
  logic [2:0] vol;
  logic       mute;
  logic       pwm1, stb1, pwm4, stb4;
  logic [7:0] lvl1, lvl4;

  int checks = 0;
  int errors = 0;

  always #10 clk50mhz = ~clk50mhz;

  audio_mixer_pwm #(.SAMPLE_PERIODS(1)) dut1 (
    .clk50mhz(clk50mhz), .rst_n(rst_n),
    .ch0_in(ch0), .ch1_in(ch1), .ch2_in(ch2), .ch3_in(ch3),
    .ch_en(ch_en), .master_vol(vol), .mute(mute),
    .pwm_out(pwm1), .level_out(lvl1), .sample_strobe(stb1)
  );

  audio_mixer_pwm #(.SAMPLE_PERIODS(4)) dut4 (
    .clk50mhz(clk50mhz), .rst_n(rst4_n),
    .ch0_in(ch0), .ch1_in(ch1), .ch2_in(ch2), .ch3_in(ch3),
    .ch_en(ch_en), .master_vol(vol), .mute(mute),
    .pwm_out(pwm4), .level_out(lvl4), .sample_strobe(stb4)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk50mhz);
    #1;
  endtask

  task automatic wait_stb1(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (stb1 !== 1'b1 && n < 3000);
  endtask

  task automatic wait_stb4(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (stb4 !== 1'b1 && n < 5000);
  endtask

  // Advance to the next duty update of dut1 (first cycle of a period).
  task automatic sync1(input string tag);
    int n;
    wait_stb1(n);
    check(tag, int'(stb1), 1);
  endtask

  // Counts pwm_out high clocks over one 256-clock period, starting at a period start.
  task automatic measure1(output int hi);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      hi += int'(pwm1);
      tick();
    end
  endtask

  function automatic int ref_level(input int a, input int b, input int c, input int d,
                                   input int en, input int v, input int m);
    int s;
    s = ((en & 1) != 0 ? a : 0) + ((en & 2) != 0 ? b : 0)
      + ((en & 4) != 0 ? c : 0) + ((en & 8) != 0 ? d : 0);
    return (m != 0) ? 0 : (s * (v + 1)) / 2;
  endfunction

  task automatic set_all(input int v);
    ch0 = 4'd15; ch1 = 4'd15; ch2 = 4'd15; ch3 = 4'd15;
    ch_en = 4'hF; vol = 3'(v);
  endtask

  initial begin
    int n, hi, exp;
    rst_n = 1'b0; rst4_n = 1'b0;
    ch0 = '0; ch1 = '0; ch2 = '0; ch3 = '0; ch_en = '0; vol = '0; mute = 1'b0;
    repeat (3) tick();
    check("rst_pwm", int'(pwm1), 0);
    check("rst_level", int'(lvl1), 0);
    check("rst_strobe", int'(stb1), 0);
    check("rst_pwm4", int'(pwm4), 0);
    check("rst_level4", int'(lvl4), 0);

    rst_n = 1'b1; rst4_n = 1'b1;
    wait_stb1(n);
    check("first_strobe_delay", n, 256);
    check("level_after_first_update", int'(lvl1), 0);
    tick();
    check("strobe_one_cycle", int'(stb1), 0);

    // Full scale
    set_all(7);
    sync1("sync_full");
    check("full_level", int'(lvl1), 240);
    measure1(hi);
    check("full_high_clocks", hi, 240);

    // Masking and volume
    ch0 = 4'd15; ch1 = 4'd8; ch2 = 4'd0; ch3 = 4'd0; ch_en = 4'b0001; vol = 3'd3;
    sync1("sync_mask1");
    check("mask_ch0_vol3", int'(lvl1), 30);
    ch_en = 4'b0011;
    sync1("sync_mask2");
    check("mask_ch01_vol3", int'(lvl1), 46);

    // Glitch-free mid-period volume change
    set_all(7);
    sync1("sync_glitch");
    check("glitch_pre_level", int'(lvl1), 240);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      if (i == 100) vol = 3'd0;
      hi += int'(pwm1);
      tick();
    end
    check("glitch_current_period", hi, 240);
    check("glitch_next_level", int'(lvl1), 30);
    measure1(hi);
    check("glitch_next_period", hi, 30);

    // Mute
    vol = 3'd7;
    sync1("sync_mute_pre");
    check("mute_pre_level", int'(lvl1), 240);
    mute = 1'b1;
`ifdef AUDIO_MIXER_SOFT_MUTE_EN
    for (int k = 1; k <= 30; k++) begin
      sync1("sync_ramp_down");
      check("ramp_down", int'(lvl1), 240 - 8 * k);
    end
    mute = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      sync1("sync_ramp_up");
      check("ramp_up", int'(lvl1), 8 * k);
    end
`else
    sync1("sync_mute");
    check("mute_level", int'(lvl1), 0);
    measure1(hi);
    check("mute_high_clocks", hi, 0);
    mute = 1'b0;
    sync1("sync_unmute");
    check("unmute_level", int'(lvl1), 240);
`endif

    // Input latency around the update boundary
    sync1("sync_lat");
    repeat (254) tick();
    vol = 3'd0;
    sync1("sync_lat_late");
    check("late_change_missed", int'(lvl1), 240);
    sync1("sync_lat_late2");
    check("late_change_next", int'(lvl1), 30);
    repeat (253) tick();
    vol = 3'd7;
    sync1("sync_lat_ontime");
    check("ontime_change_taken", int'(lvl1), 240);

    // Randomized mixes against the arithmetic model
    for (int r = 0; r < 10; r++) begin
      int a, b, c, d, en, v, m;
      a = $urandom_range(15); b = $urandom_range(15);
      c = $urandom_range(15); d = $urandom_range(15);
      en = $urandom_range(15); v = $urandom_range(7);
`ifdef AUDIO_MIXER_SOFT_MUTE_EN
      m = 0;
`else
      m = ($urandom_range(3) == 0) ? 1 : 0;
`endif
      ch0 = 4'(a); ch1 = 4'(b); ch2 = 4'(c); ch3 = 4'(d);
      ch_en = 4'(en); vol = 3'(v); mute = 1'(m);
      exp = ref_level(a, b, c, d, en, v, m);
      sync1("sync_rand");
      check("rand_level", int'(lvl1), exp);
      measure1(hi);
      check("rand_high_clocks", hi, exp);
    end
    mute = 1'b0;

    // SAMPLE_PERIODS=4: spacing and asynchronous mid-period reset
    set_all(7);
    rst4_n = 1'b0;
    tick();
    rst4_n = 1'b1;
    wait_stb4(n);
    check("sp4_first_strobe", n, 1024);
    check("sp4_level", int'(lvl4), 240);
    wait_stb4(n);
    check("sp4_spacing", n, 1024);
    repeat (50) tick();
    check("sp4_pwm_high_mid", int'(pwm4), 1);
    #3;
    rst4_n = 1'b0;
    #1;
    check("sp4_async_pwm", int'(pwm4), 0);
    check("sp4_async_level", int'(lvl4), 0);
    @(posedge clk50mhz);
    #1;
    rst4_n = 1'b1;
    wait_stb4(n);
    check("sp4_restart_strobe", n, 1024);
    check("sp4_restart_level", int'(lvl4), 240);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
